view_scheduler: RTL and testbench
=================================

Name: view_scheduler

Overview:
- Sequences the seven-segment debug display between the syscall print value, the register file and data RAM.
- Auto-scroll mode walks reg 0..31, then RAM words 0..RAM_WORDS-1, dwelling a fixed time on each entry. Manual stepping is also supported.
- Print requests preempt the scan for a hold time, then the scan resumes where it left off.
- Drives the source select and window indices consumed by the display ROM builder; sits between the debounced buttons and the display path.

Parameters:
- DWELL_TICKS, 50_000_000, clk_in cycles per scanned entry (min 1, 32-bit).
- PRINT_HOLD, 200_000_000, clk_in cycles a print value stays shown (min 1, 32-bit).
- RAM_WORDS, 64, scanned RAM words (power of 2, 2..64).

Ports:
- clk_in  in  1  board clock.
- CLR_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin scanning from IDLE.
- stop  in  1  one-cycle pulse; return to IDLE.
- step  in  1  one-cycle pulse; advance one entry now.
- hold  in  1  level; freezes the dwell timer.
- print_req  in  1  one-cycle pulse; new print value valid.
- print_data  in  32  value to show on print_req.
- print_ack  out  1  one-cycle pulse; print latched.
- print_value  out  32  latched print value.
- view_src  out  2  0=PRINT, 1=REG, 2=RAM, 3=CYCLE.
- reg_idx  out  5  register window index.
- ram_idx  out  6  RAM word window index (word address, i.e. byte address >> 2).
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, on CLR_n low, including mid-operation):
  - state=IDLE; view_src=0; reg_idx=0; ram_idx=0; print_value=0; print_ack=0; busy=0; dwell and hold counters=0.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- States: IDLE, SCAN_REG, SCAN_RAM, PRINT (plus SCAN_CYC with option).
- view_src per state: IDLE=0, SCAN_REG=1, SCAN_RAM=2, PRINT=0.
- IDLE:
  - start -> SCAN_REG, reg_idx=0, ram_idx=0, dwell counter cleared.
  - step is ignored.
- Dwell counter:
  - Increments each cycle in SCAN_* while hold=0.
  - At DWELL_TICKS-1 it wraps to 0 and generates an advance.
  - hold=1 freezes the count and suppresses advance; step still works.
- step in SCAN_*: advances immediately and clears the dwell counter.
- Advance in SCAN_REG: reg_idx+1. At reg_idx=31: reg_idx=0, ram_idx=0, go to SCAN_RAM.
- Advance in SCAN_RAM: ram_idx+1. At RAM_WORDS-1: ram_idx=0, reg_idx=0, go to SCAN_REG (continuous loop).
- print_req (any state, highest priority):
  - Latch print_data into print_value.
  - print_ack=1 for exactly one cycle.
  - If not already in PRINT, save the return state; indices are retained.
  - Enter PRINT and clear the hold counter.
- PRINT:
  - Hold counter counts regardless of hold.
  - At PRINT_HOLD-1: return to the saved state (IDLE if entered from IDLE) with the dwell counter cleared.
- print_req inside PRINT: relatch, re-ack, restart the hold counter; the return state is unchanged.
- Simultaneous events, priority: CLR_n > print_req > stop > step > dwell advance.
  - print_req with stop: print taken, saved return state becomes IDLE.
- stop from any state -> IDLE immediately (including PRINT); indices retained, print_value retained.
- start while not IDLE is ignored.

Optional Feature:
- Macro VIEW_CYCLE_EN.
- Defined: the SCAN_RAM wrap goes to SCAN_CYC (view_src=3) for one dwell period or one step, then to SCAN_REG with reg_idx=0. hold and print preemption apply as in the other SCAN_* states.
- Undefined: SCAN_CYC does not exist, view_src never equals 3, and the RAM wrap goes directly to SCAN_REG.

Decomposition:
- Package view_pkg:
  - state encoding (IDLE, SCAN_REG, SCAN_RAM, SCAN_CYC, PRINT);
  - view_src codes VS_PRINT=0, VS_REG=1, VS_RAM=2, VS_CYCLE=3;
  - NUM_REGS=32.
- Sub-module dwell_timer: 32-bit up-counter with enable, synchronous clear and a terminal-count pulse at LIMIT-1. Instantiated twice (dwell and print hold).

Test Plan (DWELL_TICKS=4, PRINT_HOLD=10, RAM_WORDS=4):
1. Reset, then start -> view_src=1 and reg_idx=0 next cycle; reg_idx increments every 4 cycles; after reg 31, view_src=2 with ram_idx=0; after ram_idx=3, back to view_src=1 with reg_idx=0.
2. In SCAN_REG at reg_idx=5, hold=1 for 20 cycles -> reg_idx stays 5. Pulse step during hold -> reg_idx=6 next cycle.
3. At reg_idx=7, print_req with print_data=32'hDEADBEEF -> next cycle: print_ack=1 for 1 cycle, view_src=0, print_value=DEADBEEF. After 10 cycles: view_src=1 with reg_idx=7.
4. In PRINT, second print_req 5 cycles in with 32'h1234 -> print_value=1234, second ack, PRINT lasts 10 cycles from the second request.
5. print_req and stop in the same cycle during SCAN_RAM -> PRINT for 10 cycles, then IDLE with busy=0. Drop CLR_n mid-scan -> all outputs return to reset values asynchronously.
6. VIEW_CYCLE_EN defined: after ram_idx=3 dwell -> view_src=3 for 4 cycles, then view_src=1 with reg_idx=0. Undefined: view_src never equals 3.

Source files
------------

// File: rtl/view_pkg.sv
// Shared encodings for the seven-segment view scheduler: FSM states,
// view source codes and helpers that map a state onto its display source.
package view_pkg;

  localparam int unsigned NUM_REGS = 32;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SCAN_REG = 3'd1;
  localparam logic [2:0] ST_SCAN_RAM = 3'd2;
  localparam logic [2:0] ST_SCAN_CYC = 3'd3;
  localparam logic [2:0] ST_PRINT    = 3'd4;

  typedef enum logic [1:0] {
    VS_PRINT = 2'd0,
    VS_REG   = 2'd1,
    VS_RAM   = 2'd2,
    VS_CYCLE = 2'd3
  } view_src_e;

  // IDLE and PRINT both show the latched print value.
  function automatic view_src_e state_src(input logic [2:0] st);
    case (st)
      ST_SCAN_REG: return VS_REG;
      ST_SCAN_RAM: return VS_RAM;
      ST_SCAN_CYC: return VS_CYCLE;
      default:     return VS_PRINT;
    endcase
  endfunction

  function automatic logic is_scan(input logic [2:0] st);
    return (st == ST_SCAN_REG) || (st == ST_SCAN_RAM) || (st == ST_SCAN_CYC);
  endfunction

endpackage

// File: rtl/view_scheduler_dwell_timer.sv
// 32-bit up-counter with enable and synchronous clear; tc_o pulses on the
// enabled cycle at LIMIT-1, where the count wraps back to zero.
module dwell_timer #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [31:0] LAST = LIMIT - 32'd1;

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/view_scheduler.sv
// Debug display sequencer: scans registers then RAM words, preempted by
// print requests. Build option VIEW_CYCLE_EN adds a cycle-count view after RAM.
module view_scheduler
  import view_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 50_000_000,
  parameter int unsigned PRINT_HOLD  = 200_000_000,
  parameter int unsigned RAM_WORDS   = 64
) (
  input  logic        clk_in,
  input  logic        CLR_n,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        hold,
  input  logic        print_req,
  input  logic [31:0] print_data,
  output logic        print_ack,
  output logic [31:0] print_value,
  output logic [1:0]  view_src,
  output logic [4:0]  reg_idx,
  output logic [5:0]  ram_idx,
  output logic        busy
);

  localparam logic [4:0] REG_LAST = 5'(NUM_REGS - 1);
  localparam logic [5:0] RAM_LAST = 6'(RAM_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  ret_q, ret_d;
  logic [4:0]  reg_idx_q, reg_idx_d;
  logic [5:0]  ram_idx_q, ram_idx_d;
  logic [31:0] print_value_q, print_value_d;
  logic        print_ack_q, print_ack_d;
  logic [1:0]  view_src_q, view_src_d;
  logic        busy_q, busy_d;

  logic dwell_en, dwell_clr, dwell_tc;
  logic hold_en, hold_clr, hold_tc;
  logic advance;

  assign dwell_en = is_scan(state_q) && !hold;
  assign hold_en  = (state_q == ST_PRINT);
  assign advance  = step || dwell_tc;

  dwell_timer #(.LIMIT(DWELL_TICKS)) u_dwell (
    .clk_i  (clk_in),
    .rst_ni (CLR_n),
    .en_i   (dwell_en),
    .clr_i  (dwell_clr),
    .tc_o   (dwell_tc)
  );

  dwell_timer #(.LIMIT(PRINT_HOLD)) u_print_hold (
    .clk_i  (clk_in),
    .rst_ni (CLR_n),
    .en_i   (hold_en),
    .clr_i  (hold_clr),
    .tc_o   (hold_tc)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    reg_idx_d     = reg_idx_q;
    ram_idx_d     = ram_idx_q;
    print_value_d = print_value_q;
    print_ack_d   = 1'b0;
    dwell_clr     = 1'b0;
    hold_clr      = 1'b0;

    if (print_req) begin
      print_value_d = print_data;
      print_ack_d   = 1'b1;
      hold_clr      = 1'b1;
      state_d       = ST_PRINT;
      // A concurrent stop means the print returns to IDLE; a repeat print
      // keeps the original return point.
      if (stop) begin
        ret_d = ST_IDLE;
      end else if (state_q != ST_PRINT) begin
        ret_d = state_q;
      end
    end else if (stop) begin
      state_d = ST_IDLE;
    end else begin
      if (is_scan(state_q)) begin
        dwell_clr = step;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_SCAN_REG;
            reg_idx_d = '0;
            ram_idx_d = '0;
            dwell_clr = 1'b1;
          end
        end
        ST_SCAN_REG: begin
          if (advance) begin
            if (reg_idx_q == REG_LAST) begin
              reg_idx_d = '0;
              ram_idx_d = '0;
              state_d   = ST_SCAN_RAM;
            end else begin
              reg_idx_d = reg_idx_q + 5'd1;
            end
          end
        end
        ST_SCAN_RAM: begin
          if (advance) begin
            if (ram_idx_q == RAM_LAST) begin
              ram_idx_d = '0;
              reg_idx_d = '0;
`ifdef VIEW_CYCLE_EN
              state_d   = ST_SCAN_CYC;
`else
              state_d   = ST_SCAN_REG;
`endif
            end else begin
              ram_idx_d = ram_idx_q + 6'd1;
            end
          end
        end
`ifdef VIEW_CYCLE_EN
        ST_SCAN_CYC: begin
          if (advance) begin
            reg_idx_d = '0;
            state_d   = ST_SCAN_REG;
          end
        end
`endif
        ST_PRINT: begin
          if (hold_tc) begin
            state_d   = ret_q;
            dwell_clr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they track it exactly.
    view_src_d = state_src(state_d);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q       <= ST_IDLE;
      ret_q         <= ST_IDLE;
      reg_idx_q     <= '0;
      ram_idx_q     <= '0;
      print_value_q <= '0;
      print_ack_q   <= 1'b0;
      view_src_q    <= VS_PRINT;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      reg_idx_q     <= reg_idx_d;
      ram_idx_q     <= ram_idx_d;
      print_value_q <= print_value_d;
      print_ack_q   <= print_ack_d;
      view_src_q    <= view_src_d;
      busy_q        <= busy_d;
    end
  end

  assign print_ack   = print_ack_q;
  assign print_value = print_value_q;
  assign view_src    = view_src_q;
  assign reg_idx     = reg_idx_q;
  assign ram_idx     = ram_idx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_view_scheduler.sv
// Self-checking bench for view_scheduler: hand-written vector table, directed
// corner sequences and random stimulus against a scan-position reference model.
module tb_view_scheduler;

  localparam int DW = 4;
  localparam int PH = 10;
  localparam int RW = 4;
`ifdef VIEW_CYCLE_EN
  localparam int SEQ_LEN = 32 + RW + 1;
`else
  localparam int SEQ_LEN = 32 + RW;
`endif

  logic        clk_in = 1'b0;
  logic        CLR_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, hold = 1'b0;
  logic        print_req = 1'b0;
  logic [31:0] print_data = '0;
  logic        print_ack;
  logic [31:0] print_value;
  logic [1:0]  view_src;
  logic [4:0]  reg_idx;
  logic [5:0]  ram_idx;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit saw_cycle_src = 1'b0;

  always #5 clk_in = ~clk_in;

  view_scheduler #(.DWELL_TICKS(DW), .PRINT_HOLD(PH), .RAM_WORDS(RW)) dut (
    .clk_in      (clk_in),
    .CLR_n       (CLR_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .hold        (hold),
    .print_req   (print_req),
    .print_data  (print_data),
    .print_ack   (print_ack),
    .print_value (print_value),
    .view_src    (view_src),
    .reg_idx     (reg_idx),
    .ram_idx     (ram_idx),
    .busy        (busy)
  );

  // Reference model: a linear position along the scan sequence
  // (0..31 registers, then RAM words, then the optional cycle view).
  bit          m_run, m_prt, m_ret, m_ack;
  int          m_pos, m_dwell, m_hcnt;
  logic [31:0] m_pv;

  function automatic void model_reset();
    m_run = 0; m_prt = 0; m_ret = 0; m_ack = 0;
    m_pos = 0; m_dwell = 0; m_hcnt = 0; m_pv = '0;
  endfunction

  function automatic void model_step(bit s, bit p, bit st, bit h, bit pr, logic [31:0] pd);
    m_ack = 0;
    if (pr) begin
      m_pv = pd; m_ack = 1; m_hcnt = 0;
      if (p) m_ret = 0;
      else if (!m_prt) m_ret = m_run;
      m_prt = 1;
    end else if (p) begin
      m_run = 0; m_prt = 0;
    end else if (m_prt) begin
      m_hcnt++;
      if (m_hcnt == PH) begin m_prt = 0; m_run = m_ret; m_dwell = 0; end
    end else if (m_run) begin
      if (st) begin
        m_pos = (m_pos + 1) % SEQ_LEN; m_dwell = 0;
      end else if (!h) begin
        m_dwell++;
        if (m_dwell == DW) begin m_dwell = 0; m_pos = (m_pos + 1) % SEQ_LEN; end
      end
    end else if (s) begin
      m_run = 1; m_pos = 0; m_dwell = 0;
    end
  endfunction

  function automatic logic [31:0] exp_src();
    if (m_prt || !m_run) return 0;
    if (m_pos < 32) return 1;
    if (m_pos < 32 + RW) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_reg();
    return (m_pos < 32) ? 32'(m_pos) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ram();
    return (m_pos >= 32 && m_pos < 32 + RW) ? 32'(m_pos - 32) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (view_src == 2'd3) saw_cycle_src = 1'b1;
    check("model_src",   32'(view_src),  exp_src());
    check("model_reg",   32'(reg_idx),   exp_reg());
    check("model_ram",   32'(ram_idx),   exp_ram());
    check("model_busy",  32'(busy),      32'(m_prt || m_run));
    check("model_ack",   32'(print_ack), 32'(m_ack));
    check("model_value", print_value,    m_pv);
  endtask

  task automatic apply(input bit s, p, st, h, pr, input logic [31:0] pd);
    start = s; stop = p; step = st; hold = h; print_req = pr; print_data = pd;
    @(posedge clk_in); #1;
    model_step(s, p, st, h, pr, pd);
    compare_model();
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) apply(0, 0, 0, h, 0, 32'd0);
  endtask

  task automatic do_reset();
    start = 0; stop = 0; step = 0; hold = 0; print_req = 0; print_data = '0;
    CLR_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 CLR_n = 1'b1;
    compare_model();
  endtask

  typedef struct {
    bit s, p, st, h, pr;
    logic [31:0] pd;
    logic [1:0]  src;
    logic [4:0]  ri;
    logic [5:0]  mi;
    bit busy, ack;
    logic [31:0] pv;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0,0,1,0,0,32'h0,  2'd0, 5'd0, 6'd0, 0, 0, 32'h0};   // step ignored in IDLE
    vecs[1]  = '{1,0,0,0,0,32'h0,  2'd1, 5'd0, 6'd0, 1, 0, 32'h0};
    vecs[2]  = '{0,0,1,0,0,32'h0,  2'd1, 5'd1, 6'd0, 1, 0, 32'h0};
    vecs[3]  = '{0,0,1,0,0,32'h0,  2'd1, 5'd2, 6'd0, 1, 0, 32'h0};
    vecs[4]  = '{1,0,0,0,0,32'h0,  2'd1, 5'd2, 6'd0, 1, 0, 32'h0};   // start ignored
    vecs[5]  = '{0,0,0,1,0,32'h0,  2'd1, 5'd2, 6'd0, 1, 0, 32'h0};
    vecs[6]  = '{0,0,0,0,0,32'h0,  2'd1, 5'd2, 6'd0, 1, 0, 32'h0};
    vecs[7]  = '{0,0,0,0,1,32'hA5, 2'd0, 5'd2, 6'd0, 1, 1, 32'hA5};
    vecs[8]  = '{0,1,0,0,0,32'h0,  2'd0, 5'd2, 6'd0, 0, 0, 32'hA5};  // stop leaves PRINT
    vecs[9]  = '{1,0,0,0,0,32'h0,  2'd1, 5'd0, 6'd0, 1, 0, 32'hA5};
    vecs[10] = '{0,0,1,0,0,32'h0,  2'd1, 5'd1, 6'd0, 1, 0, 32'hA5};
    vecs[11] = '{0,1,1,0,0,32'h0,  2'd0, 5'd1, 6'd0, 0, 0, 32'hA5};  // stop beats step
    vecs[12] = '{1,0,0,0,1,32'h5A, 2'd0, 5'd1, 6'd0, 1, 1, 32'h5A};  // print beats start

    do_reset();
    check("rst_src",   32'(view_src), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_value", print_value,   32'd0);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].s, vecs[i].p, vecs[i].st, vecs[i].h, vecs[i].pr, vecs[i].pd);
      check($sformatf("vec%0d_src", i),   32'(view_src),  32'(vecs[i].src));
      check($sformatf("vec%0d_reg", i),   32'(reg_idx),   32'(vecs[i].ri));
      check($sformatf("vec%0d_ram", i),   32'(ram_idx),   32'(vecs[i].mi));
      check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d_ack", i),   32'(print_ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_value", i), print_value,    vecs[i].pv);
    end

    // Full scan loop with dwell advances.
    do_reset();
    apply(1, 0, 0, 0, 0, 32'd0);
    check("scan_start_src", 32'(view_src), 32'd1);
    check("scan_start_reg", 32'(reg_idx),  32'd0);
    idle(4, 0);
    check("scan_reg1", 32'(reg_idx), 32'd1);
    idle(124, 0);
    check("scan_ram_src", 32'(view_src), 32'd2);
    check("scan_ram0",    32'(ram_idx),  32'd0);
    idle(4 * RW, 0);
`ifdef VIEW_CYCLE_EN
    check("scan_cyc_src", 32'(view_src), 32'd3);
    idle(4, 0);
`endif
    check("scan_wrap_src", 32'(view_src), 32'd1);
    check("scan_wrap_reg", 32'(reg_idx),  32'd0);

    // Hold freezes the dwell; step still advances.
    idle(20, 0);
    check("hold_pre_reg", 32'(reg_idx), 32'd5);
    idle(20, 1);
    check("hold_frozen_reg", 32'(reg_idx), 32'd5);
    apply(0, 0, 1, 1, 0, 32'd0);
    check("hold_step_reg", 32'(reg_idx), 32'd6);
    idle(4, 0);
    check("pre_print_reg", 32'(reg_idx), 32'd7);

    // Print preemption and resume.
    apply(0, 0, 0, 0, 1, 32'hDEADBEEF);
    check("print_ack",   32'(print_ack), 32'd1);
    check("print_src",   32'(view_src),  32'd0);
    check("print_value", print_value,    32'hDEADBEEF);
    idle(1, 0);
    check("print_ack_once", 32'(print_ack), 32'd0);
    idle(8, 0);
    check("print_still_src", 32'(view_src), 32'd0);
    idle(1, 0);
    check("print_resume_src", 32'(view_src), 32'd1);
    check("print_resume_reg", 32'(reg_idx),  32'd7);

    // Re-request inside PRINT restarts the hold time.
    apply(0, 0, 0, 0, 1, 32'h1111);
    idle(4, 0);
    apply(0, 0, 0, 0, 1, 32'h1234);
    check("reprint_ack",   32'(print_ack), 32'd1);
    check("reprint_value", print_value,    32'h1234);
    idle(9, 0);
    check("reprint_hold_src", 32'(view_src), 32'd0);
    idle(1, 0);
    check("reprint_resume_src", 32'(view_src), 32'd1);
    check("reprint_resume_reg", 32'(reg_idx),  32'd7);

    // print_req with stop in SCAN_RAM returns to IDLE afterwards.
    for (int i = 0; i < 25; i++) apply(0, 0, 1, 0, 0, 32'd0);
    check("stepped_ram_src", 32'(view_src), 32'd2);
    apply(0, 1, 0, 0, 1, 32'hCAFE);
    check("prstop_src",  32'(view_src), 32'd0);
    check("prstop_busy", 32'(busy),     32'd1);
    idle(9, 0);
    check("prstop_hold_busy", 32'(busy), 32'd1);
    idle(1, 0);
    check("prstop_idle_busy", 32'(busy),     32'd0);
    check("prstop_idle_src",  32'(view_src), 32'd0);

    // Asynchronous reset mid-scan.
    apply(1, 0, 0, 0, 0, 32'd0);
    idle(6, 0);
    #2 CLR_n = 1'b0;
    #1;
    check("arst_src",   32'(view_src),  32'd0);
    check("arst_reg",   32'(reg_idx),   32'd0);
    check("arst_ram",   32'(ram_idx),   32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_ack",   32'(print_ack), 32'd0);
    check("arst_value", print_value,    32'd0);
    model_reset();
    @(posedge clk_in);
    #1 CLR_n = 1'b1;

    // Random traffic against the model.
    begin
      bit h = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 9) == 0) h = ~h;
        apply($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 5) == 0, h, $urandom_range(0, 39) == 0, $urandom);
      end
    end

`ifndef VIEW_CYCLE_EN
    check("no_cycle_src", 32'(saw_cycle_src), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
